// File: rtl/decoder_scan_n_if.sv
// Bus bundle for the registered scanning decoder: control inputs and
// decoded/status outputs. The bench drives through master, the decoder
// attaches as slave.
interface decoder_scan_n_if #(
   parameter int N       = 5,
   parameter int DWELL_W = 8
);
   localparam int OUTS = 2 ** N;

   logic               E;
   logic [N-1:0]       B;
   logic               mode;
   logic               start;
   logic [DWELL_W-1:0] dwell;
   logic [OUTS-1:0]    L;
   logic [N-1:0]       idx;
   logic               busy;
   logic               done;

   modport master (
      output E, B, mode, start, dwell,
      input  L, idx, busy, done
   );

   modport slave (
      input  E, B, mode, start, dwell,
      output L, idx, busy, done
   );
endinterface

// File: rtl/decoder_scan_n.sv
// Registered N-to-2**N one-hot decoder with a scan mode that walks the
// active line from a start index up to the top line, holding each line
// for dwell+1 cycles. All outputs come straight from registers.
module decoder_scan_n #(
   parameter int N          = 5,
   parameter int DWELL_W    = 8,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   decoder_scan_n_if.slave   bus
);
   localparam int              OUTS     = 2 ** N;
   localparam logic [N-1:0]    TOP_IDX  = '1;
   localparam logic [OUTS-1:0] ONE_LINE = OUTS'(1);

   typedef enum logic {
      IDLE,
      SCAN
   } state_t;

   state_t             state_q,     state_d;
   logic [OUTS-1:0]    line_q,      line_d;
   logic [N-1:0]       idx_q,       idx_d;
   logic               busy_q,      busy_d;
   logic               done_q,      done_d;
   logic [DWELL_W-1:0] cnt_q,       cnt_d;
   logic [DWELL_W-1:0] dwellHold_q, dwellHold_d;

   // Next-state logic: direct decode or scan acceptance while idle, line
   // stepping with dwell countdown while scanning; done is a one-cycle pulse.
   always_comb begin
      state_d     = state_q;
      line_d      = line_q;
      idx_d       = idx_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      cnt_d       = cnt_q;
      dwellHold_d = dwellHold_q;
      case (state_q)
         IDLE: begin
            if (!bus.mode) begin
               line_d = bus.E ? (ONE_LINE << bus.B) : '0;
               idx_d  = bus.E ? bus.B : '0;
            end else if (bus.start && bus.E) begin
               state_d     = SCAN;
               busy_d      = 1'b1;
               line_d      = ONE_LINE << bus.B;
               idx_d       = bus.B;
               cnt_d       = bus.dwell;
               dwellHold_d = bus.dwell;
            end else begin
               line_d = '0;
               idx_d  = '0;
            end
         end
         SCAN: begin
            if (!bus.E) begin
               state_d = IDLE;
               line_d  = '0;
               idx_d   = '0;
               busy_d  = 1'b0;
               cnt_d   = '0;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - DWELL_W'(1);
            end else if (idx_q != TOP_IDX) begin
               idx_d  = idx_q + N'(1);
               line_d = line_q << 1;
               cnt_d  = dwellHold_q;
            end else begin
               state_d = IDLE;
               line_d  = '0;
               idx_d   = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
      endcase
   end

   // State and output registers, cleared immediately by the async reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         line_q      <= '0;
         idx_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cnt_q       <= '0;
         dwellHold_q <= '0;
      end else begin
         state_q     <= state_d;
         line_q      <= line_d;
         idx_q       <= idx_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cnt_q       <= cnt_d;
         dwellHold_q <= dwellHold_d;
      end
   end

   assign bus.L    = ACTIVE_LOW ? ~line_q : line_q;
   assign bus.idx  = idx_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
endmodule

// File: tb/tb_decoder_scan_n.sv
// Directed bench for decoder_scan_n: an active-high N=5 build exercises
// direct decode, scanning, abort, boundaries and async reset; an
// active-low N=3 build checks output polarity.
module tb_decoder_scan_n;
   logic clk;
   logic rst;
   int   compared;
   int   mismatched;

   decoder_scan_n_if #(.N(5), .DWELL_W(8)) b5 ();
   decoder_scan_n_if #(.N(3), .DWELL_W(8)) b3 ();

   decoder_scan_n #(.N(5), .DWELL_W(8), .ACTIVE_LOW(1'b0)) dut5 (
      .clk (clk),
      .rst (rst),
      .bus (b5)
   );

   decoder_scan_n #(.N(3), .DWELL_W(8), .ACTIVE_LOW(1'b1)) dut3 (
      .clk (clk),
      .rst (rst),
      .bus (b3)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Guard against a hung run.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: got no finish, required finish before 200000");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic e, input logic m, input logic [4:0] b,
                                input logic s, input logic [7:0] d);
      b5.E     = e;
      b5.mode  = m;
      b5.B     = b;
      b5.start = s;
      b5.dwell = d;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [63:0] lineOf(input int i);
      logic [31:0] one;
      one = 32'd1;
      return 64'(one << i);
   endfunction

   initial begin
      compared   = 0;
      mismatched = 0;
      rst        = 1'b1;
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 8'd0);
      b3.E = 1'b1; b3.mode = 1'b0; b3.B = 3'd5; b3.start = 1'b0; b3.dwell = 8'd0;
      #2;
      checkOutput("rst L",     64'(b5.L),    64'h0);
      checkOutput("rst idx",   64'(b5.idx),  64'h0);
      checkOutput("rst busy",  64'(b5.busy), 64'h0);
      checkOutput("rst done",  64'(b5.done), 64'h0);
      checkOutput("rst al L",  64'(b3.L),    64'hFF);

      // Direct decode, one clock latency
      @(negedge clk);
      rst = 1'b0;
      for (int b = 1; b <= 8; b++) begin
         applyStimulus(1'b1, 1'b0, 5'(b), 1'b0, 8'd0);
         if (b > 1) checkOutput("direct pre-edge", 64'(b5.L), lineOf(b - 1));
         tick();
         checkOutput("direct L",   64'(b5.L),   lineOf(b));
         checkOutput("direct idx", 64'(b5.idx), 64'(b));
         if (b == 1) checkOutput("al direct L", 64'(b3.L), 64'hDF);
         tick();
         checkOutput("direct hold", 64'(b5.L), lineOf(b));
      end
      applyStimulus(1'b0, 1'b0, 5'd8, 1'b0, 8'd0);
      tick();
      checkOutput("E low L",   64'(b5.L),   64'h0);
      checkOutput("E low idx", 64'(b5.idx), 64'h0);

      // Idle in scan mode without start
      applyStimulus(1'b1, 1'b1, 5'd28, 1'b0, 8'd2);
      b3.mode = 1'b1;
      tick();
      checkOutput("scan idle L", 64'(b5.L), 64'h0);
      checkOutput("al idle L",   64'(b3.L), 64'hFF);
      b3.mode = 1'b0;

      // Scan B=28 dwell=2, with a stray start while busy
      applyStimulus(1'b1, 1'b1, 5'd28, 1'b1, 8'd2);
      tick();
      applyStimulus(1'b1, 1'b1, 5'd28, 1'b0, 8'd2);
      for (int i = 0; i < 12; i++) begin
         checkOutput("scan L",    64'(b5.L),    lineOf(28 + i / 3));
         checkOutput("scan idx",  64'(b5.idx),  64'(28 + i / 3));
         checkOutput("scan busy", 64'(b5.busy), 64'h1);
         checkOutput("scan done", 64'(b5.done), 64'h0);
         if (i == 4) applyStimulus(1'b1, 1'b1, 5'd3, 1'b1, 8'd7);
         if (i == 5) applyStimulus(1'b1, 1'b1, 5'd28, 1'b0, 8'd2);
         tick();
      end
      checkOutput("end done", 64'(b5.done), 64'h1);
      checkOutput("end L",    64'(b5.L),    64'h0);
      checkOutput("end idx",  64'(b5.idx),  64'h0);
      checkOutput("end busy", 64'(b5.busy), 64'h0);
      tick();
      checkOutput("done pulse", 64'(b5.done), 64'h0);

      // Abort by dropping E at idx=5
      applyStimulus(1'b1, 1'b1, 5'd0, 1'b1, 8'd0);
      tick();
      applyStimulus(1'b1, 1'b1, 5'd0, 1'b0, 8'd0);
      for (int i = 0; i <= 5; i++) begin
         checkOutput("abort walk idx", 64'(b5.idx), 64'(i));
         if (i < 5) tick();
      end
      applyStimulus(1'b0, 1'b1, 5'd0, 1'b0, 8'd0);
      tick();
      checkOutput("abort L",    64'(b5.L),    64'h0);
      checkOutput("abort idx",  64'(b5.idx),  64'h0);
      checkOutput("abort busy", 64'(b5.busy), 64'h0);
      checkOutput("abort done", 64'(b5.done), 64'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("abort no done", 64'(b5.done), 64'h0);
      end
      applyStimulus(1'b1, 1'b1, 5'd2, 1'b1, 8'd0);
      tick();
      applyStimulus(1'b1, 1'b1, 5'd2, 1'b0, 8'd0);
      checkOutput("restart idx",  64'(b5.idx),  64'h2);
      checkOutput("restart L",    64'(b5.L),    lineOf(2));
      checkOutput("restart busy", 64'(b5.busy), 64'h1);
      for (int i = 3; i <= 31; i++) begin
         tick();
         checkOutput("dwell0 idx", 64'(b5.idx), 64'(i));
      end
      tick();
      checkOutput("restart done", 64'(b5.done), 64'h1);

      // Single-line scan at the top index, then back-to-back scan
      applyStimulus(1'b1, 1'b1, 5'd31, 1'b1, 8'd0);
      tick();
      checkOutput("top L",    64'(b5.L),    64'h8000_0000);
      checkOutput("top idx",  64'(b5.idx),  64'd31);
      checkOutput("top busy", 64'(b5.busy), 64'h1);
      applyStimulus(1'b1, 1'b1, 5'd30, 1'b1, 8'd0);
      tick();
      checkOutput("top done", 64'(b5.done), 64'h1);
      checkOutput("top end L", 64'(b5.L),   64'h0);
      tick();
      checkOutput("b2b busy", 64'(b5.busy), 64'h1);
      checkOutput("b2b idx",  64'(b5.idx),  64'd30);
      checkOutput("b2b done", 64'(b5.done), 64'h0);
      applyStimulus(1'b1, 1'b1, 5'd30, 1'b0, 8'd0);
      tick();
      checkOutput("b2b idx2", 64'(b5.idx),  64'd31);
      tick();
      checkOutput("b2b end",  64'(b5.done), 64'h1);

      // Async reset between edges at idx=10
      applyStimulus(1'b1, 1'b1, 5'd0, 1'b1, 8'd0);
      tick();
      applyStimulus(1'b1, 1'b1, 5'd0, 1'b0, 8'd0);
      repeat (10) tick();
      checkOutput("pre-rst idx", 64'(b5.idx), 64'd10);
      #2 rst = 1'b1;
      #1;
      checkOutput("async L",    64'(b5.L),    64'h0);
      checkOutput("async idx",  64'(b5.idx),  64'h0);
      checkOutput("async busy", 64'(b5.busy), 64'h0);
      checkOutput("async al L", 64'(b3.L),    64'hFF);
      #1 rst = 1'b0;
      applyStimulus(1'b1, 1'b0, 5'd9, 1'b0, 8'd0);
      @(negedge clk);
      checkOutput("post-rst L",    64'(b5.L),    lineOf(9));
      checkOutput("post-rst idx",  64'(b5.idx),  64'd9);
      checkOutput("post-rst done", 64'(b5.done), 64'h0);
      checkOutput("post-rst al L", 64'(b3.L),    64'hDF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/decoder_scan_n.md
Name: decoder_scan_n

Overview:
- Parametrised, registered successor to the 5-to-32 enable decoder: N-bit select drives a 2**N one-hot output.
- Adds a scan mode that walks the active line from a start index to the top line, holding each line for a programmable dwell.
- Used for row/digit strobing and sequenced enables, and as a drop-in registered decoder in direct mode.

Parameters:
- N, 5, select width; output width is OUTS = 2**N.
- DWELL_W, 8, width of the dwell-count input and internal dwell counter.
- ACTIVE_LOW, 0, when 1 the L output is bitwise inverted; all internal logic is active-high.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- E  input  1  global enable; low forces outputs inactive and aborts a scan.
- B  input  N  direct-mode select; start index in scan mode.
- mode  input  1  0 = direct decode, 1 = scan; sampled only when idle.
- start  input  1  scan start strobe; effective only when mode=1, E=1 and idle.
- dwell  input  DWELL_W  each line is held for dwell+1 cycles; sampled at start.
- L  output  OUTS  registered one-hot output, polarity per ACTIVE_LOW.
- idx  output  N  index of the currently active line; 0 when none.
- busy  output  1  high while scanning.
- done  output  1  one-cycle pulse after the last line's dwell completes.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; L inactive (all 0, or all 1 if ACTIVE_LOW); idx=0; busy=0; done=0; dwell counter=0.
  - Reset mid-scan aborts with no done pulse.
- States: IDLE, SCAN. done is a registered pulse, not a separate state.
- IDLE, mode=0 (direct):
  - Next edge: L = E ? (1<<B) : 0; idx = E ? B : 0.
  - Latency is one clock; start is ignored.
- IDLE, mode=1:
  - Without an accepted start: L=0, idx=0.
  - Start is accepted when start=1 and E=1 at an edge. At that edge: state→SCAN, busy=1, L=1<<B, idx=B, cnt=dwell.
  - Start with E=0 is ignored.
- SCAN, each edge with E=1:
  - If cnt≠0: cnt−1; L and idx hold.
  - If cnt=0 and idx<OUTS−1: idx+1, L shifts left one position, cnt reloads from the dwell value latched at start.
  - If cnt=0 and idx=OUTS−1: state→IDLE, L=0, idx=0, busy=0, done=1 for exactly one cycle.
- SCAN with E=0 at an edge: abort. state→IDLE, L=0, idx=0, busy=0, done stays 0.
- While busy, changes to start, mode, B and dwell are ignored. After a scan ends, mode, B and dwell are re-sampled.
- Start index B=OUTS−1 produces a single-line scan of dwell+1 cycles, then done.
- Scan length in cycles is (OUTS−B)·(dwell+1); done is asserted on the edge after the last dwell cycle.
- In the cycle done=1 the block is IDLE. A start present in that same cycle is accepted, so back-to-back scans are possible.
- dwell=0 advances one line per clock.
- Arithmetic:
  - idx never wraps; the top-of-range check prevents overflow.
  - cnt is unsigned DWELL_W bits; a dwell of all-ones is legal.
- ACTIVE_LOW inverts only the registered L bits at the port. idx, busy and done are unaffected.
- There are no combinational paths from inputs to outputs.

Test Plan:
- Reset then direct decode (N=5, mode=0, E=1): rst pulse → L=0, busy=0. Apply B=1,2,3…8, 2 cycles each → L=0x2,0x4,0x8…0x100, each one clock after B changes. E=0 → L=0 next edge.
- Scan with dwell (N=5, B=28, dwell=2, 1-cycle start): L=1<<28 for 3 cycles, then bits 29, 30, 31 for 3 cycles each. Total 12 busy cycles; done=1 on the next cycle with L=0, idx=0.
- Abort: start scan B=0, dwell=0; drop E after idx=5 → next edge L=0, busy=0, done never asserts. Re-raise E with start → scan restarts at B.
- Boundaries: B=31, dwell=0 → L=0x80000000 for 1 cycle, then done. Start held during the done cycle → second scan begins immediately. Start while busy → no effect on idx sequence.
- Async reset mid-scan: assert rst between clock edges at idx=10 → L, idx, busy clear immediately without a clock. After release, mode=0 direct decoding works.
- ACTIVE_LOW=1 build (N=3): direct decode B=5 → L=8'hDF. Idle → L=8'hFF. Reset → L=8'hFF.
